// File: rtl/elevator_scheduler.sv
// SCAN-policy car controller: latches floor calls, tracks position from motor
// step ticks, shapes an accel/decel speed profile and times the door dwell.
module elevator_scheduler #(
    parameter int FLOORS          = 4,
    parameter int STEPS_PER_FLOOR = 200,
    parameter int RAMP_STEPS      = 40,
    parameter int DOOR_CYCLES     = 100000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] call_req,
    input  logic              step_tick,
    output logic              motor_start,
    output logic              motor_dir,
    output logic [1:0]        motor_speed,
    output logic [2:0]        cur_floor,
    output logic [FLOORS-1:0] pending,
    output logic              door_open,
    output logic              moving
);
    localparam int SW = $clog2(STEPS_PER_FLOOR);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS_PER_FLOOR - 1);
    localparam logic [SW-1:0] RUN_MAX   = SW'(2 * RAMP_STEPS);
    localparam logic [SW-1:0] RAMP_ONE  = SW'(RAMP_STEPS);
    localparam logic [SW-1:0] DECEL_HI  = SW'(STEPS_PER_FLOOR - RAMP_STEPS);
    localparam logic [SW-1:0] DECEL_LO  = SW'(STEPS_PER_FLOOR - 2 * RAMP_STEPS);
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);
    localparam logic [2:0]    TOP       = 3'(FLOORS - 1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t            state_q, state_d;
    logic [2:0]        floor_q, floor_d, nxt;
    logic [FLOORS-1:0] pend_q, pend_d;
    logic              dir_q, dir_d;
    logic [SW-1:0]     step_q, step_d, run_q, run_d;
    logic [DW-1:0]     door_q, door_d;
    logic              start_q, mdir_q, open_q, moving_q;
    logic [1:0]        speed_q;

    function automatic logic bit_at(input logic [FLOORS-1:0] v, input logic [2:0] fl);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < FLOORS; j++)
            if (j == int'(fl)) hit = v[j];
        return hit;
    endfunction

    function automatic logic [FLOORS-1:0] clr(input logic [FLOORS-1:0] v, input logic [2:0] fl);
        logic [FLOORS-1:0] r;
        r = v;
        for (int j = 0; j < FLOORS; j++)
            if (j == int'(fl)) r[j] = 1'b0;
        return r;
    endfunction

    // Any call strictly above (up=1) or strictly below (up=0) floor fl.
    function automatic logic beyond(input logic [FLOORS-1:0] v, input logic [2:0] fl, input logic up);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < FLOORS; j++)
            if (up ? (j > int'(fl)) : (j < int'(fl))) hit = hit | v[j];
        return hit;
    endfunction

    function automatic logic stop_next(input logic [FLOORS-1:0] v, input logic [2:0] fl, input logic up);
        logic [2:0] nx;
        nx = up ? fl + 3'd1 : fl - 3'd1;
        return bit_at(v, nx) | ~beyond(v, nx, up) | (nx == 3'd0) | (nx == TOP);
    endfunction

    // Decel bands take priority; the medium decel band never exceeds accel speed.
    function automatic logic [1:0] speed_of(input state_t st, input logic [SW-1:0] step,
                                            input logic [SW-1:0] run, input logic stop);
        logic [1:0] accel;
        if (run < RAMP_ONE)     accel = 2'b01;
        else if (run < RUN_MAX) accel = 2'b10;
        else                    accel = 2'b11;
        if (st != MOVE)                 return 2'b00;
        if (stop && step >= DECEL_HI)   return 2'b01;
        if (stop && step >= DECEL_LO)   return (accel == 2'b01) ? 2'b01 : 2'b10;
        return accel;
    endfunction

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        step_d  = step_q;
        run_d   = run_q;
        door_d  = door_q;
        pend_d  = pend_q | call_req;
        nxt     = dir_q ? floor_q + 3'd1 : floor_q - 3'd1;
        case (state_q)
            IDLE: begin
                if (bit_at(pend_q, floor_q)) begin
                    state_d = DOOR;
                    door_d  = '0;
                    pend_d  = clr(pend_d, floor_q);
                end else if (beyond(pend_q, floor_q, 1'b1) &&
                             (dir_q || !beyond(pend_q, floor_q, 1'b0))) begin
                    state_d = MOVE;
                    dir_d   = 1'b1;
                    step_d  = '0;
                    run_d   = '0;
                end else if (beyond(pend_q, floor_q, 1'b0)) begin
                    state_d = MOVE;
                    dir_d   = 1'b0;
                    step_d  = '0;
                    run_d   = '0;
                end
            end
            MOVE: begin
                if (step_tick) begin
                    step_d = step_q + 1'b1;
                    if (run_q < RUN_MAX) run_d = run_q + 1'b1;
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        floor_d = nxt;
                        if (bit_at(pend_q | call_req, nxt)) begin
                            state_d = DOOR;
                            door_d  = '0;
                            pend_d  = clr(pend_d, nxt);
                        end else if (!beyond(pend_q | call_req, nxt, dir_q)) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            DOOR: begin
                // A call for the open floor only extends the dwell.
                pend_d = clr(pend_d, floor_q);
                if (bit_at(call_req, floor_q)) door_d = '0;
                else if (door_q == DOOR_LAST)  state_d = IDLE;
                else                           door_d = door_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            floor_q  <= '0;
            pend_q   <= '0;
            dir_q    <= 1'b1;
            step_q   <= '0;
            run_q    <= '0;
            door_q   <= '0;
            start_q  <= 1'b0;
            mdir_q   <= 1'b0;
            speed_q  <= 2'b00;
            open_q   <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            pend_q   <= pend_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            run_q    <= run_d;
            door_q   <= door_d;
            start_q  <= (state_d == MOVE);
            mdir_q   <= (state_d == MOVE) && dir_d;
            speed_q  <= speed_of(state_d, step_d, run_d, stop_next(pend_d, floor_d, dir_d));
            open_q   <= (state_d == DOOR);
            moving_q <= (state_d == MOVE);
        end
    end

    assign motor_start = start_q;
    assign motor_dir   = mdir_q;
    assign motor_speed = speed_q;
    assign cur_floor   = floor_q;
    assign pending     = pend_q;
    assign door_open   = open_q;
    assign moving      = moving_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with a door-service scoreboard.
module tb_elevator_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] call_req = 4'b0000;
    logic       step_tick = 1'b0;
    logic       motor_start, motor_dir, door_open, moving;
    logic [1:0] motor_speed;
    logic [2:0] cur_floor;
    logic [3:0] pending;

    int   vectors = 0;
    int   miscompares = 0;
    int   exp_q[$];
    logic door_prev = 1'b0;

    logic [1:0] spd_tab [24] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3,
                                 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3,
                                 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1};
    logic [1:0] spd_short [8] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};

    always #5 clk = ~clk;

    elevator_scheduler #(
        .FLOORS(4), .STEPS_PER_FLOOR(8), .RAMP_STEPS(2), .DOOR_CYCLES(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .call_req(call_req), .step_tick(step_tick),
        .motor_start(motor_start), .motor_dir(motor_dir), .motor_speed(motor_speed),
        .cur_floor(cur_floor), .pending(pending), .door_open(door_open), .moving(moving)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_cycle();
        int f;
        @(posedge clk);
        #1;
        if (door_open && !door_prev) begin
            if (exp_q.size() > 0) f = exp_q.pop_front();
            else                  f = 238;
            check("door_floor", 32'(cur_floor), 32'(f));
        end
        door_prev = door_open;
    endtask

    task automatic advance(input logic tk);
        step_tick = tk;
        tick_cycle();
        step_tick = 1'b0;
    endtask

    task automatic tick_once();
        repeat (3) advance(1'b0);
        advance(1'b1);
    endtask

    task automatic tick_chk(input string tag, input logic [1:0] spd);
        repeat (3) advance(1'b0);
        check(tag, 32'(motor_speed), 32'(spd));
        advance(1'b1);
    endtask

    task automatic door_wait(input string tag, input int exp_n, input logic tk);
        int n;
        n = 0;
        while (door_open && n < 50) begin
            n++;
            advance(tk);
        end
        check(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_start"}, 32'(motor_start), 0);
        check({tag, "_dir"},   32'(motor_dir), 0);
        check({tag, "_speed"}, 32'(motor_speed), 0);
        check({tag, "_floor"}, 32'(cur_floor), 0);
        check({tag, "_pend"},  32'(pending), 0);
        check({tag, "_door"},  32'(door_open), 0);
        check({tag, "_mov"},   32'(moving), 0);
    endtask

    initial begin
        repeat (3) advance(1'b0);
        rst_n = 1'b1;
        check_reset("rst");

        // Full trip 0 -> 3 with speed profile
        call_req = 4'b1000;
        exp_q.push_back(3);
        advance(1'b0);
        call_req = 4'b0000;
        check("latch", 32'(pending), 8);
        advance(1'b0);
        check("start_up", 32'(motor_start), 1);
        check("dir_up", 32'(motor_dir), 1);
        check("moving", 32'(moving), 1);
        for (int i = 0; i < 24; i++) begin
            tick_chk("spd_up", spd_tab[i]);
            if (i == 7)  check("floor1", 32'(cur_floor), 1);
            if (i == 15) check("floor2", 32'(cur_floor), 2);
        end
        check("arr3_door", 32'(door_open), 1);
        check("arr3_floor", 32'(cur_floor), 3);
        check("arr3_start", 32'(motor_start), 0);
        door_wait("dwell3", 10, 1'b0);
        check("pend_clr", 32'(pending), 0);
        check("idle_mov", 32'(moving), 0);

        // Reset in the middle of a downward move
        call_req = 4'b0001;
        advance(1'b0);
        call_req = 4'b0000;
        advance(1'b0);
        check("start_dn", 32'(motor_start), 1);
        check("dir_dn", 32'(motor_dir), 0);
        repeat (5) tick_once();
        rst_n = 1'b0;
        advance(1'b0);
        rst_n = 1'b1;
        check_reset("midrst");
        repeat (4) advance(1'b1);
        check("idle_tick_floor", 32'(cur_floor), 0);
        check("idle_tick_start", 32'(motor_start), 0);

        // Call for floor 2 appears mid-segment 1->2 during a trip to 3
        call_req = 4'b1000;
        exp_q.push_back(3);
        advance(1'b0);
        call_req = 4'b0000;
        advance(1'b0);
        repeat (11) tick_once();
        call_req = 4'b0100;
        exp_q.push_front(2);
        advance(1'b0);
        call_req = 4'b0000;
        check("mid_latch", 32'(pending), 12);
        advance(1'b0);
        advance(1'b0);
        advance(1'b1);
        tick_chk("dec4", 2'd2);
        tick_chk("dec5", 2'd2);
        tick_chk("dec6", 2'd1);
        tick_chk("dec7", 2'd1);
        check("arr2_door", 32'(door_open), 1);
        check("arr2_floor", 32'(cur_floor), 2);
        check("arr2_pend", 32'(pending), 8);
        door_wait("dwell2", 10, 1'b0);
        advance(1'b0);
        check("resume_start", 32'(motor_start), 1);
        check("resume_dir", 32'(motor_dir), 1);
        for (int i = 0; i < 8; i++) tick_chk("spd_short", spd_short[i]);
        check("arr3b_floor", 32'(cur_floor), 3);
        door_wait("dwell3b", 10, 1'b0);

        // At floor 2 heading up, calls at 0 and 3: serve 3 first
        rst_n = 1'b0;
        advance(1'b0);
        rst_n = 1'b1;
        check("rst2_floor", 32'(cur_floor), 0);
        call_req = 4'b0100;
        exp_q.push_back(2);
        advance(1'b0);
        call_req = 4'b0000;
        advance(1'b0);
        repeat (16) tick_once();
        check("at2_floor", 32'(cur_floor), 2);
        door_wait("dwell2b", 10, 1'b0);
        call_req = 4'b1001;
        exp_q.push_back(3);
        exp_q.push_back(0);
        advance(1'b0);
        call_req = 4'b0000;
        check("both_pend", 32'(pending), 9);
        advance(1'b0);
        check("scan_up", 32'(motor_dir), 1);
        repeat (8) tick_once();
        check("scan3_floor", 32'(cur_floor), 3);
        door_wait("dwell3c", 10, 1'b0);
        advance(1'b0);
        check("scan_dn", 32'(motor_dir), 0);
        check("scan_dn_start", 32'(motor_start), 1);
        repeat (24) tick_once();
        check("scan0_floor", 32'(cur_floor), 0);
        check("scan0_door", 32'(door_open), 1);
        door_wait("dwell0", 10, 1'b0);

        // Call at the current floor while idle, then dwell restart
        call_req = 4'b0001;
        exp_q.push_back(0);
        advance(1'b0);
        call_req = 4'b0000;
        check("here_pend", 32'(pending), 1);
        check("here_wait", 32'(door_open), 0);
        advance(1'b0);
        check("here_door", 32'(door_open), 1);
        check("here_start", 32'(motor_start), 0);
        check("here_clr", 32'(pending), 0);
        repeat (7) advance(1'b1);
        check("door_cyc8", 32'(door_open), 1);
        call_req = 4'b0001;
        advance(1'b0);
        call_req = 4'b0000;
        check("restart_nolatch", 32'(pending), 0);
        door_wait("restart_dwell", 10, 1'b1);
        check("door_tick_floor", 32'(cur_floor), 0);
        check("door_tick_start", 32'(motor_start), 0);
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
